// File: rtl/rom_burst_reader_if.sv
// Stream/control bundle for rom_burst_reader: burst request in, word stream out.
interface rom_burst_reader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 1
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] length;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] addr_out;
    logic              last;
    logic              busy;
    logic              done;

    // Requester / consumer side
    modport master (
        output start, start_addr, length, out_ready,
        input  out_valid, data_out, addr_out, last, busy, done
    );

    // ROM sequencer side
    modport slave (
        input  start, start_addr, length, out_ready,
        output out_valid, data_out, addr_out, last, busy, done
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Parametrised read-only table with a burst sequencer that streams consecutive
// words (address wrapping modulo depth) over a valid/ready interface.
module rom_burst_reader #(
    parameter int unsigned                     ADDR_W = 4,
    parameter int unsigned                     DATA_W = 1,
    parameter logic [DATA_W*(2**ADDR_W)-1:0]   INIT   = 16'hE7A5
) (
    input  logic                clock,
    input  logic                reset_n,
    rom_burst_reader_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_remain, w_remain_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_last, w_last_nxt;
    logic              r_done, w_done_nxt;
    logic [ADDR_W-1:0] w_addr_inc;

    // Table lookup; word k occupies INIT[k*DATA_W +: DATA_W]
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return INIT[int'(a) * int'(DATA_W) +: DATA_W];
    endfunction

    // Natural ADDR_W-bit wrap gives the modulo-DEPTH advance for free
    assign w_addr_inc = r_addr + ADDR_W'(1);

    // State and output registers; async clear, outputs drop to zero on reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_remain <= w_remain_nxt;
            r_data   <= w_data_nxt;
            r_last   <= w_last_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state: launch on start in IDLE, advance or finish on each handshake
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_remain_nxt = r_remain;
        w_data_nxt   = r_data;
        w_last_nxt   = r_last;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_last_nxt = 1'b0;
                if (bus.start) begin
                    w_state_nxt  = STREAM;
                    w_addr_nxt   = bus.start_addr;
                    w_remain_nxt = bus.length;
                    w_data_nxt   = rom_word(bus.start_addr);
                    w_last_nxt   = (bus.length == '0);
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_addr_nxt   = w_addr_inc;
                        w_remain_nxt = r_remain - ADDR_W'(1);
                        w_data_nxt   = rom_word(w_addr_inc);
                        w_last_nxt   = (r_remain == ADDR_W'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    // A word is presented exactly while streaming
    assign bus.out_valid = (r_state == STREAM);
    assign bus.busy      = (r_state == STREAM);
    assign bus.data_out  = r_data;
    assign bus.addr_out  = r_addr;
    assign bus.last      = r_last;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Randomised self-checking bench for rom_burst_reader against an arithmetic
// model: word i of a burst is at (start_addr + i) mod 16, value = INIT bit.
module tb_rom_burst_reader;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    rom_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT(16'hE7A5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] ref_rom = 16'hE7A5;
    logic [15:0] full_bits;

    function automatic logic ref_word(input int a);
        return ref_rom[a % 16];
    endfunction

    // Request a burst and follow it word by word until the done cycle.
    // stall_pct < 0 selects the fixed pattern: ready low 3 cycles per word.
    task automatic burst(input int sa, input int len, input int stall_pct,
                         input bit noise, input bit chain, input string name);
        int         idx;
        int         budget;
        int         wait_cnt;
        logic [8:0] obs;
        logic [8:0] exp;
        if (!chain) @(negedge clock);
        bus.start      = 1'b1;
        bus.start_addr = 4'(sa);
        bus.length     = 4'(len);
        bus.out_ready  = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        idx      = 0;
        wait_cnt = 0;
        budget   = (len + 1) * 40 + 20;
        while (idx <= len && budget > 0) begin
            exp = {1'b1, 1'b1, (idx == len), 1'b0, 4'((sa + idx) % 16), ref_word(sa + idx)};
            obs = {bus.out_valid, bus.busy, bus.last, bus.done, bus.addr_out, bus.data_out};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s word %0d: got v/b/l/d/addr/data=%b want %b", name, idx, obs, exp);
            end
            full_bits[idx % 16] = bus.data_out;
            if (stall_pct < 0) begin
                bus.out_ready = (wait_cnt == 3);
                wait_cnt      = bus.out_ready ? 0 : wait_cnt + 1;
            end else begin
                bus.out_ready = ($urandom_range(99) >= stall_pct);
            end
            if (noise) begin
                bus.start      = 1'($urandom_range(1));
                bus.start_addr = 4'($urandom);
                bus.length     = 4'($urandom);
            end
            @(negedge clock);
            if (bus.out_ready) idx++;
            budget--;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        n_tests++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d words want %0d", name, idx, len + 1);
        end
        n_tests++;
        if ({bus.out_valid, bus.busy, bus.last, bus.done} !== 4'b0001) begin
            n_fail++;
            $display("FAIL %s done cycle: got v/b/l/d=%b want 0001", name,
                     {bus.out_valid, bus.busy, bus.last, bus.done});
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
        reset_n = 1'b0;
        #23;
        n_tests++;
        if ({bus.out_valid, bus.busy, bus.last, bus.done, bus.addr_out, bus.data_out} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want 0",
                     {bus.out_valid, bus.busy, bus.last, bus.done, bus.addr_out, bus.data_out});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_tests++;
            if ({bus.out_valid, bus.busy, bus.last, bus.done, bus.addr_out, bus.data_out} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %b want 0", i,
                         {bus.out_valid, bus.busy, bus.last, bus.done, bus.addr_out, bus.data_out});
            end
        end
    endtask

    task automatic test_simple_burst();
        burst(0, 3, 0, 1'b0, 1'b0, "simple");
    endtask

    task automatic test_wrap();
        burst(14, 3, 0, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_single_full();
        burst(5, 0, 0, 1'b0, 1'b0, "single");
        burst(0, 15, 0, 1'b0, 1'b0, "full");
        n_tests++;
        if (full_bits !== 16'hE7A5) begin
            n_fail++;
            $display("FAIL full_table: got %h want e7a5", full_bits);
        end
    endtask

    task automatic test_backpressure();
        burst(8, 2, -1, 1'b1, 1'b0, "backpressure");
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        bus.start = 1'b1; bus.start_addr = 4'd3; bus.length = 4'd5; bus.out_ready = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({bus.out_valid, bus.addr_out} !== {1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL reset_mid second word: got v/addr=%b want 10100", {bus.out_valid, bus.addr_out});
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.busy, bus.last, bus.done, bus.addr_out, bus.data_out} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_mid async clear: got %b want 0",
                     {bus.out_valid, bus.busy, bus.last, bus.done, bus.addr_out, bus.data_out});
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_tests++;
            if ({bus.out_valid, bus.done} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid held %0d: got v/d=%b want 00", i, {bus.out_valid, bus.done});
            end
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if ({bus.out_valid, bus.busy, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid recovery: got v/b/d=%b want 000", {bus.out_valid, bus.busy, bus.done});
        end
    endtask

    task automatic test_back_to_back();
        burst(1, 2, 0, 1'b0, 1'b0, "b2b_first");
        burst(9, 1, 0, 1'b0, 1'b1, "b2b_second");
        burst(15, 2, 30, 1'b0, 1'b1, "b2b_third");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            burst(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(60)),
                  1'b1, 1'($urandom_range(1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_simple_burst();
        test_wrap();
        test_single_full();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
Parametrised synchronous ROM with an integrated burst-read sequencer. Contents are set by a packed parameter. On a start pulse, the block streams a run of consecutive words out through a valid/ready interface. The address wraps modulo depth. It generalises the fixed 16x1 combinational lookup ROM to any width and depth, with registered output, backpressure and burst control. It sits between control logic and any consumer that needs table contents as a stream.

Parameters:
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
DATA_W, 1, word width in bits.
INIT, 16'hE7A5, packed contents of DATA_W*DEPTH bits; word k = INIT[k*DATA_W +: DATA_W].

Ports:
clock  input  1  single clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  burst request; sampled only in IDLE.
start_addr  input  ADDR_W  first word address of the burst.
length  input  ADDR_W  burst word count minus 1 (0 = 1 word, DEPTH-1 = full table).
out_valid  output  1  data_out/addr_out/last hold a valid word.
out_ready  input  1  consumer accepts the word when high with out_valid.
data_out  output  DATA_W  ROM word.
addr_out  output  ADDR_W  address of the word on data_out.
last  output  1  high with the final word of the burst.
busy  output  1  high while a burst is in progress (state STREAM).
done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid, busy, last and done are 0; data_out and addr_out are 0; internal address and remaining counter are 0.
- FSM states: IDLE, STREAM. busy = (state == STREAM); out_valid equals busy.
- IDLE + start=1 at an edge: latch start_addr and length. Next state is STREAM.
  - First word is registered: out_valid=1, addr_out=start_addr, data_out=ROM[start_addr], last=(length==0).
  - Latency: first word is visible 1 cycle after start is sampled.
- IDLE + start=0: outputs hold out_valid=0, last=0.
- STREAM, handshake (out_valid & out_ready):
  - If last=0: next edge advances addr_out to (addr_out+1) mod DEPTH, loads the matching ROM word, and decrements remaining. last=1 when remaining reaches 0.
  - If last=1: next edge goes to IDLE; out_valid and last go to 0; done=1 for exactly that one cycle.
- STREAM, out_ready=0: data_out, addr_out and last hold stable. No word is skipped or duplicated.
- Throughput: one word per cycle when out_ready is held high. A burst of N words takes N cycles from first valid to last handshake.
- Address arithmetic: ADDR_W-bit unsigned, natural wrap from DEPTH-1 to 0. The remaining counter is ADDR_W bits, so a full-table burst (length = DEPTH-1) cannot overflow.
- start during STREAM is ignored; the latched burst parameters are unaffected.
- start in the done cycle (state already IDLE) is accepted, giving back-to-back bursts with a one-cycle gap in out_valid.
- data_out is don't-care while out_valid=0 but must not be X after reset.
- reset_n asserted mid-burst: all outputs clear immediately (asynchronously). No done pulse is produced. After release the block is in IDLE.
- Contents are read-only; there is no write path.

Test Plan:
- Reset then idle: reset_n=0, release, 5 cycles with start=0 -> out_valid=busy=done=last=0 and data_out=0 throughout.
- Simple burst (INIT=16'hE7A5): start_addr=0, length=3, out_ready=1 -> addr_out 0,1,2,3 with data_out 1,0,1,0 on consecutive cycles; last on addr 3; done pulses 1 cycle later.
- Wrap-around: start_addr=14, length=3 -> addr_out 14,15,0,1 with data_out 1,1,1,0; last on addr 1.
- Single word and full table: start_addr=5, length=0 -> one word, data_out=1 with last=1. Then start_addr=0, length=15 -> 16 words, which reassembled LSB-first equal 16'hE7A5.
- Backpressure: burst start_addr=8, length=2 with out_ready low for 3 cycles on each word -> each word held stable, sequence 8,9,10 → 1,1,1, no loss or duplication. A start pulse mid-burst is ignored.
- Reset mid-burst and back-to-back: assert reset_n=0 during the second word -> outputs 0 immediately, no done. After recovery, start asserted in the done cycle -> new burst begins with out_valid after a one-cycle gap.
